// File: rtl/dbg_bridge_if.sv
// Byte link between a host/UART and the debug bridge: an rx command stream
// plus a valid/ready transmit handshake for response bytes.
interface dbg_bridge_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output rx_data, rx_valid, tx_ready, input tx_data, tx_valid);
    modport slave  (input rx_data, rx_valid, tx_ready, output tx_data, tx_valid);
endinterface

// File: rtl/dbg_bridge.sv
// Debug/control bridge: halts, steps and resumes the core and peeks probes over a byte link.
// Optional build macro DBG_CHECKSUM_EN appends an XOR checksum byte to every response.
module dbg_bridge #(
    parameter int         N   = 64,
    parameter int         MW  = 32,
    parameter int         MA  = 8,
    parameter logic [7:0] ACK = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    dbg_bridge_if.slave       link,
    output logic              run,
    output logic [4:0]        checkra,
    input  logic [N-1:0]      checkr,
    output logic [MA-1:0]     checkma,
    input  logic [MW-1:0]     checkm,
    input  logic [7:0]        pclow,
    output logic              overrun,
    output logic              busy
);

`ifdef DBG_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif
    localparam int SW = (N > MW) ? N : MW;
    localparam int TW = SW + 8;
    localparam int CW = $clog2(SW / 8 + 2);

    localparam logic [7:0] OP_RD_REG = 8'h01;
    localparam logic [7:0] OP_RD_MEM = 8'h02;
    localparam logic [7:0] OP_HALT   = 8'h03;
    localparam logic [7:0] OP_RESUME = 8'h04;
    localparam logic [7:0] OP_STEP   = 8'h05;
    localparam logic [7:0] OP_RD_PC  = 8'h06;

    typedef enum logic [1:0] {IDLE = 2'd0, OPERAND = 2'd1, FETCH = 2'd2, SEND = 2'd3} state_t;
    typedef enum logic [1:0] {SEL_REG = 2'd0, SEL_MEM = 2'd1, SEL_PC = 2'd2} sel_t;

    state_t          state_r, state_next;
    sel_t            sel_r, sel_next;
    logic [TW-1:0]   shift_r, shift_next;
    logic [CW-1:0]   count_r, count_next;
    logic            run_r, run_next;
    logic            pend_r, pend_next;
    logic [4:0]      checkra_r, checkra_next;
    logic [MA-1:0]   checkma_r, checkma_next;
    logic            overrun_r, overrun_next;
    logic            tx_valid_r, tx_valid_next;
    logic            busy_r, busy_next;
    logic [SW-1:0]   load_data_s;
    int              load_nb_s;
    logic            load_s;

    function automatic logic [7:0] xor_fold(input logic [SW-1:0] v);
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 0; i < SW / 8; i++) begin
            acc = acc ^ v[i*8 +: 8];
        end
        return acc;
    endfunction

    // The checksum slot sits directly above the payload; it stays zero when the feature is off.
    function automatic logic [TW-1:0] frame(input logic [SW-1:0] v, input int nb);
        logic [TW-1:0] f;
        f = '0;
        f[SW-1:0] = v;
        f[nb*8 +: 8] = (CS != 0) ? xor_fold(v) : 8'h00;
        return f;
    endfunction

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            sel_r      <= SEL_REG;
            shift_r    <= '0;
            count_r    <= '0;
            run_r      <= 1'b1;
            pend_r     <= 1'b0;
            checkra_r  <= 5'd0;
            checkma_r  <= '0;
            overrun_r  <= 1'b0;
            tx_valid_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_next;
            sel_r      <= sel_next;
            shift_r    <= shift_next;
            count_r    <= count_next;
            run_r      <= run_next;
            pend_r     <= pend_next;
            checkra_r  <= checkra_next;
            checkma_r  <= checkma_next;
            overrun_r  <= overrun_next;
            tx_valid_r <= tx_valid_next;
            busy_r     <= busy_next;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next = state_r;
        case (state_r)
            IDLE: begin
                if (link.rx_valid) begin
                    case (link.rx_data)
                        OP_RD_REG, OP_RD_MEM: state_next = OPERAND;
                        OP_RD_PC:             state_next = FETCH;
                        default:              state_next = SEND;
                    endcase
                end else begin
                    state_next = IDLE;
                end
            end
            OPERAND: begin
                if (link.rx_valid) begin
                    state_next = FETCH;
                end else begin
                    state_next = OPERAND;
                end
            end
            FETCH:   state_next = SEND;
            SEND: begin
                if (tx_valid_r && link.tx_ready && count_r == CW'(1)) begin
                    state_next = IDLE;
                end else begin
                    state_next = SEND;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath and output next values.
    always_comb begin
        sel_next     = sel_r;
        shift_next   = shift_r;
        count_next   = count_r;
        checkra_next = checkra_r;
        checkma_next = checkma_r;
        load_s       = 1'b0;
        load_data_s  = '0;
        load_nb_s    = 1;
        // A step pulse lasts one cycle: whatever raised run last cycle drops it now.
        pend_next    = 1'b0;
        run_next     = pend_r ? 1'b0 : run_r;
        overrun_next = overrun_r | (link.rx_valid && (state_r == FETCH || state_r == SEND));
        case (state_r)
            IDLE: begin
                if (link.rx_valid) begin
                    case (link.rx_data)
                        OP_RD_REG: sel_next = SEL_REG;
                        OP_RD_MEM: sel_next = SEL_MEM;
                        OP_RD_PC:  sel_next = SEL_PC;
                        OP_HALT: begin
                            run_next         = 1'b0;
                            load_s           = 1'b1;
                            load_data_s[7:0] = ACK;
                        end
                        OP_RESUME: begin
                            run_next         = 1'b1;
                            load_s           = 1'b1;
                            load_data_s[7:0] = ACK;
                        end
                        OP_STEP: begin
                            load_s = 1'b1;
                            if (!run_r) begin
                                run_next         = 1'b1;
                                pend_next        = 1'b1;
                                load_data_s[7:0] = ACK;
                            end else begin
                                load_data_s[7:0] = 8'hE1;
                            end
                        end
                        default: begin
                            load_s           = 1'b1;
                            load_data_s[7:0] = 8'hEE;
                        end
                    endcase
                end else begin
                    load_s = 1'b0;
                end
            end
            OPERAND: begin
                if (link.rx_valid && sel_r == SEL_REG) begin
                    checkra_next = link.rx_data[4:0];
                end else if (link.rx_valid) begin
                    checkma_next = link.rx_data[MA-1:0];
                end else begin
                    checkra_next = checkra_r;
                end
            end
            FETCH: begin
                load_s = 1'b1;
                case (sel_r)
                    SEL_REG: begin
                        load_data_s[N-1:0] = checkr;
                        load_nb_s          = N / 8;
                    end
                    SEL_MEM: begin
                        load_data_s[MW-1:0] = checkm;
                        load_nb_s           = MW / 8;
                    end
                    default: begin
                        load_data_s[7:0] = pclow;
                        load_nb_s        = 1;
                    end
                endcase
            end
            SEND: begin
                if (tx_valid_r && link.tx_ready) begin
                    shift_next = shift_r >> 8;
                    count_next = count_r - CW'(1);
                end else begin
                    shift_next = shift_r;
                end
            end
            default: load_s = 1'b0;
        endcase
        if (load_s) begin
            shift_next = frame(load_data_s, load_nb_s);
            count_next = CW'(load_nb_s + CS);
        end else begin
            count_next = count_next;
        end
        tx_valid_next = (state_next == SEND);
        busy_next     = (state_next != IDLE);
    end

    assign link.tx_data  = shift_r[7:0];
    assign link.tx_valid = tx_valid_r;
    assign run           = run_r;
    assign checkra       = checkra_r;
    assign checkma       = checkma_r;
    assign overrun       = overrun_r;
    assign busy          = busy_r;

endmodule

// File: tb/tb_dbg_bridge.sv
// Scoreboard bench for dbg_bridge: stimulus pushes expected tx bytes, a monitor pops on each accepted byte.
module tb_dbg_bridge;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run;
    logic [4:0]  checkra;
    logic [63:0] checkr = 64'h0123456789ABCDEF;
    logic [7:0]  checkma;
    logic [31:0] checkm = 32'hDEADBEEF;
    logic [7:0]  pclow = 8'h3C;
    logic        overrun;
    logic        busy;
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_q[$];

    dbg_bridge_if bif ();

    dbg_bridge #(.N(64), .MW(32), .MA(8), .ACK(8'hA5)) dut (
        .clk(clk), .reset(reset), .link(bif.slave), .run(run),
        .checkra(checkra), .checkr(checkr), .checkma(checkma), .checkm(checkm),
        .pclow(pclow), .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    // Monitor: every accepted response byte must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset && bif.tx_valid && bif.tx_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL tx_unexpected got %h with empty queue", bif.tx_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (bif.tx_data !== e) begin
                    errors++;
                    $display("FAIL tx_byte got %h want %h", bif.tx_data, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bif.rx_data  = b;
        bif.rx_valid = 1'b1;
        tick();
        bif.rx_valid = 1'b0;
    endtask

    // Pushes a response and, when the checksum build is active, its XOR trailer.
    task automatic expect_resp(input logic [63:0] v, input int nb);
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < nb; i++) begin
            exp_q.push_back(v[i*8 +: 8]);
            x = x ^ v[i*8 +: 8];
        end
`ifdef DBG_CHECKSUM_EN
        exp_q.push_back(x);
`else
        x = 8'h00;
`endif
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL %s timeout busy %0d queued %0d", name, busy, exp_q.size());
        end
    endtask

    initial begin
        bif.rx_data  = 8'h00;
        bif.rx_valid = 1'b0;
        bif.tx_ready = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        repeat (5) tick();
        chk("rst_run", run, 1);
        chk("rst_tx_valid", bif.tx_valid, 0);
        chk("rst_tx_data", bif.tx_data, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_busy", busy, 0);
        chk("rst_checkra", checkra, 0);

        // Register read, all bytes accepted immediately.
        expect_resp(64'h0123456789ABCDEF, 8);
        send_byte(8'h01);
        send_byte(8'h03);
        wait_idle("rd_reg");
        chk("rd_reg_checkra", checkra, 3);
        chk("rd_reg_tx_done", bif.tx_valid, 0);

        // Halt, step pulse, resume, step while running.
        expect_resp(64'hA5, 1);
        send_byte(8'h03);
        chk("halt_run", run, 0);
        wait_idle("halt");
        expect_resp(64'hA5, 1);
        send_byte(8'h05);
        chk("step_pulse_hi", run, 1);
        tick();
        chk("step_pulse_lo", run, 0);
        wait_idle("step");
        chk("step_stays_halted", run, 0);
        expect_resp(64'hA5, 1);
        send_byte(8'h04);
        chk("resume_run", run, 1);
        wait_idle("resume");
        expect_resp(64'hE1, 1);
        send_byte(8'h05);
        chk("step_running_run", run, 1);
        wait_idle("step_running");

        // Memory read with back-pressure: first byte must hold.
        bif.tx_ready = 1'b0;
        expect_resp(64'hDEADBEEF, 4);
        send_byte(8'h02);
        send_byte(8'h10);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("stall_valid", bif.tx_valid, 1);
            chk("stall_data", bif.tx_data, 8'hEF);
            tick();
        end
        bif.tx_ready = 1'b1;
        wait_idle("rd_mem");
        chk("rd_mem_checkma", checkma, 8'h10);
        chk("checkra_held", checkra, 3);

        // Byte arriving during SEND is dropped and flags overrun.
        bif.tx_ready = 1'b0;
        expect_resp(64'h0123456789ABCDEF, 8);
        send_byte(8'h01);
        send_byte(8'h05);
        tick();
        send_byte(8'h77);
        chk("overrun_set", overrun, 1);
        bif.tx_ready = 1'b1;
        wait_idle("overrun_rd");
        chk("overrun_checkra", checkra, 5);
        expect_resp(64'hEE, 1);
        send_byte(8'h99);
        wait_idle("bad_op");
        chk("overrun_sticky", overrun, 1);

        // Reset in the middle of a register read response.
        expect_resp(64'hA5, 1);
        send_byte(8'h03);
        wait_idle("halt2");
        chk("halt2_run", run, 0);
        bif.tx_ready = 1'b0;
        exp_q.push_back(8'hEF);
        exp_q.push_back(8'hCD);
        send_byte(8'h01);
        send_byte(8'h03);
        tick();
        bif.tx_ready = 1'b1;
        tick();
        tick();
        bif.tx_ready = 1'b0;
        chk("third_byte", bif.tx_data, 8'hAB);
        chk("third_valid", bif.tx_valid, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_tx_valid", bif.tx_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_run", run, 1);
        chk("midrst_overrun", overrun, 0);
        chk("midrst_queue", exp_q.size(), 0);
        exp_q.delete();
        bif.tx_ready = 1'b1;
        expect_resp(64'h3C, 1);
        send_byte(8'h06);
        wait_idle("rd_pc");
        chk("final_queue", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
